b_operand_stage: RTL and testbench

// - Registered, parametrised successor to the 1-bit ALU operand-B select.
// - Conditions a WIDTH-bit op2 per 3-bit opsel, generates ALU carry-in, passes op1 and a tag through aligned.
// - Sits between decode/regfile read and the ALU; valid/ready on both sides; 2-entry skid so in_ready is registered.

---
 rtl/b_operand_stage.sv | 168 ++++++++++++++++
 tb/tb_b_operand_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/b_operand_stage.sv
// b_operand_stage: registered operand-B conditioning stage between the
// decode/regfile read and the ALU. It decodes op2 and the ALU carry-in
// from opsel, and carries op1 and a sideband tag alongside. Valid/ready
// handshakes sit on both sides. A two-slot store (main + skid) keeps
// in_ready a plain register output.
// Optional feature: define B_OPSTAGE_CNT_EN to build the saturating
// illegal-opsel counter. Without it, illegal_cnt is tied to zero.
module b_operand_stage #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [2:0]       opsel,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             cin_out,
    output logic [TAG_W-1:0] tag_out,
    output logic             err_sticky,
    input  logic             err_clr,
    output logic [CNT_W-1:0] illegal_cnt
);

    // Returns {cin, b} for one opsel; opsel 111 is illegal and yields zeros.
    function automatic logic [WIDTH:0] decode_b(input logic [2:0] sel,
                                                input logic [WIDTH-1:0] v);
        logic [WIDTH:0] r;
        r = '0;
        case (sel)
            3'b000:  r = {1'b0, v};
            3'b001:  r = {1'b1, ~v};
            3'b010:  r = '0;
            3'b011:  r = {1'b1, ~v};
            3'b100:  r = '0;
            3'b101:  r = {1'b0, {WIDTH{1'b1}}};
            3'b110:  r = {1'b0, v};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Stage p0: combinational decode of the incoming beat
    logic [WIDTH-1:0] dec_b_p0;
    logic             dec_cin_p0;
    logic             illegal_p0;

    // Decode op2/carry-in before anything is registered
    always_comb begin
        {dec_cin_p0, dec_b_p0} = decode_b(opsel, op2);
        illegal_p0             = (opsel == 3'b111);
    end

    // Stage p1: main (output) slot and skid slot
    logic             main_valid;
    logic [WIDTH-1:0] a_p1, b_p1;
    logic             cin_p1;
    logic [TAG_W-1:0] tag_p1;

    logic             skid_valid;
    logic [WIDTH-1:0] skid_a_p1, skid_b_p1;
    logic             skid_cin_p1;
    logic [TAG_W-1:0] skid_tag_p1;

    logic accept;
    logic main_free;
    logic illegal_acc;

    // in_ready is the registered inverse of skid occupancy, so no path from out_ready
    assign in_ready    = !skid_valid;
    assign accept      = in_valid && !skid_valid;
    assign main_free   = !main_valid || out_ready;
    assign illegal_acc = accept && illegal_p0;

    // Main slot: refill from skid first (FIFO order), else from the input, else empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            a_p1       <= '0;
            b_p1       <= '0;
            cin_p1     <= 1'b0;
            tag_p1     <= '0;
        end else if (main_free) begin
            if (skid_valid) begin
                main_valid <= 1'b1;
                a_p1       <= skid_a_p1;
                b_p1       <= skid_b_p1;
                cin_p1     <= skid_cin_p1;
                tag_p1     <= skid_tag_p1;
            end else if (accept) begin
                main_valid <= 1'b1;
                a_p1       <= op1;
                b_p1       <= dec_b_p0;
                cin_p1     <= dec_cin_p0;
                tag_p1     <= tag_in;
            end else begin
                main_valid <= 1'b0;
            end
        end
    end

    // Skid slot: captures a beat only while main is full and stalled; empties when main frees
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid  <= 1'b0;
            skid_a_p1   <= '0;
            skid_b_p1   <= '0;
            skid_cin_p1 <= 1'b0;
            skid_tag_p1 <= '0;
        end else if (main_free) begin
            skid_valid <= 1'b0;
        end else if (accept) begin
            skid_valid  <= 1'b1;
            skid_a_p1   <= op1;
            skid_b_p1   <= dec_b_p0;
            skid_cin_p1 <= dec_cin_p0;
            skid_tag_p1 <= tag_in;
        end
    end

    assign out_valid = main_valid;
    assign a_out     = a_p1;
    assign b_out     = b_p1;
    assign cin_out   = cin_p1;
    assign tag_out   = tag_p1;

    // Sticky illegal flag: setting on an accepted 111 beat beats a coincident clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky <= 1'b0;
        end else if (illegal_acc) begin
            err_sticky <= 1'b1;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
        end
    end

`ifdef B_OPSTAGE_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating illegal-op counter; clear plus increment together leaves one count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (illegal_acc) begin
            if (err_clr) begin
                cnt_q <= CNT_W'(1);
            end else if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else if (err_clr) begin
            cnt_q <= '0;
        end
    end

    assign illegal_cnt = cnt_q;
`else
    assign illegal_cnt = '0;
`endif

endmodule

// File: tb/tb_b_operand_stage.sv
// Bench for b_operand_stage: a two-deep FIFO reference model plus
// directed tests with literal expectations and a randomized phase.
module tb_b_operand_stage;

    localparam int WIDTH = 8;
    localparam int TAG_W = 4;
    localparam int CNT_W = 2;

    logic             clk, rst;
    logic             in_valid, in_ready;
    logic [WIDTH-1:0] op1, op2;
    logic [2:0]       opsel;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] a_out, b_out;
    logic             cin_out;
    logic [TAG_W-1:0] tag_out;
    logic             err_sticky, err_clr;
    logic [CNT_W-1:0] illegal_cnt;

    b_operand_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .opsel(opsel), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .a_out(a_out), .b_out(b_out), .cin_out(cin_out), .tag_out(tag_out),
        .err_sticky(err_sticky), .err_clr(err_clr), .illegal_cnt(illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [TAG_W-1:0] tag;
    } beat_t;

    beat_t q[$];
    logic  m_err;
    int    m_cnt;
    logic  last_acc;
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Operand-B table: pass for 0/6, invert with carry for 1/3, ones for 5, else zero
    function automatic beat_t ref_beat(input logic [2:0] s, input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] v, input logic [TAG_W-1:0] t);
        beat_t r;
        r.a = a; r.tag = t; r.cin = 1'b0; r.b = '0;
        if (s == 3'd0 || s == 3'd6) r.b = v;
        else if (s == 3'd1 || s == 3'd3) begin r.b = ~v; r.cin = 1'b1; end
        else if (s == 3'd5) r.b = {WIDTH{1'b1}};
        return r;
    endfunction

    function automatic int cnt_max();
        return (1 << CNT_W) - 1;
    endfunction

    task automatic model_reset();
        q.delete();
        m_err    = 1'b0;
        m_cnt    = 0;
        last_acc = 1'b0;
    endtask

    // Model edge: a stage holding at most two beats, head visible at the output
    task automatic model_edge();
        logic acc, drn, ill;
        acc = in_valid && (q.size() < 2);
        drn = (q.size() > 0) && out_ready;
        ill = acc && (opsel == 3'd7);
        if (drn) void'(q.pop_front());
        if (acc) q.push_back(ref_beat(opsel, op1, op2, tag_in));
        if (ill) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
        if (ill) m_cnt = err_clr ? 1 : ((m_cnt < cnt_max()) ? m_cnt + 1 : m_cnt);
        else if (err_clr) m_cnt = 0;
        last_acc = acc;
    endtask

    task automatic check_all();
        beat_t h;
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        chk("err_sticky", 32'(err_sticky), 32'(m_err));
`ifdef B_OPSTAGE_CNT_EN
        chk("illegal_cnt", 32'(illegal_cnt), 32'(m_cnt));
`else
        chk("illegal_cnt", 32'(illegal_cnt), 32'd0);
`endif
        if (q.size() > 0) begin
            h = q[0];
            chk("a_out", 32'(a_out), 32'(h.a));
            chk("b_out", 32'(b_out), 32'(h.b));
            chk("cin_out", 32'(cin_out), 32'(h.cin));
            chk("tag_out", 32'(tag_out), 32'(h.tag));
        end
    endtask

    // One clock: inputs already driven; model follows the edge, outputs checked on the falling edge
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input logic v, input logic [2:0] s, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] t);
        in_valid = v; opsel = s; op1 = a; op2 = b; tag_in = t;
    endtask

    logic [WIDTH-1:0] exp_b [8];
    logic             exp_c [8];
    logic [WIDTH-1:0] held_b;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_b = '{8'hA5, 8'h5A, 8'h00, 8'h5A, 8'h00, 8'hFF, 8'hA5, 8'h00};
        exp_c = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        rst = 1'b1; err_clr = 1'b0; out_ready = 1'b0;
        drive(1'b0, 3'd0, '0, '0, '0);
        model_reset();
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_b_out", 32'(b_out), 32'd0);
        chk("rst_err", 32'(err_sticky), 32'd0);
        chk("rst_cnt", 32'(illegal_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Decode sweep: one cycle latency, full throughput
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), 8'(i + 16), 8'hA5, 4'(i));
            step();
            chk("sweep_b", 32'(b_out), 32'(exp_b[i]));
            chk("sweep_cin", 32'(cin_out), 32'(exp_c[i]));
            chk("sweep_valid", 32'(out_valid), 32'd1);
        end
        chk("sweep_err", 32'(err_sticky), 32'd1);

        // Illegal op: clear, then clear coincident with a new 111 accept
        drive(1'b0, 3'd0, '0, '0, '0);
        err_clr = 1'b1;
        step();
        chk("clr_err", 32'(err_sticky), 32'd0);
        drive(1'b1, 3'd7, 8'h11, 8'h22, 4'h3);
        step();
        chk("set_wins", 32'(err_sticky), 32'd1);
        err_clr = 1'b0;
        for (int i = 0; i < 5; i++) step();
`ifdef B_OPSTAGE_CNT_EN
        chk("cnt_sat", 32'(illegal_cnt), 32'd3);
`else
        chk("cnt_tied", 32'(illegal_cnt), 32'd0);
`endif

        // Streaming 16 beats, tags 0..15, out_valid continuous
        drive(1'b0, 3'd0, '0, '0, '0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        step();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 3'd0, 8'(i * 3), 8'(i * 7), 4'(i));
            step();
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_tag", 32'(tag_out), 32'(i));
        end
        drive(1'b0, 3'd0, '0, '0, '0);
        step();

        // Backpressure: beats 1,2 accepted, beat 3 held off
        out_ready = 1'b0;
        drive(1'b1, 3'd1, 8'h01, 8'h0F, 4'd1);
        step();
        chk("bp_ready1", 32'(in_ready), 32'd1);
        drive(1'b1, 3'd0, 8'h02, 8'h33, 4'd2);
        step();
        chk("bp_ready2", 32'(in_ready), 32'd0);
        held_b = b_out;
        drive(1'b1, 3'd5, 8'h03, 8'h44, 4'd3);
        step();
        step();
        chk("bp_stable", 32'(b_out), 32'(held_b));
        chk("bp_tag1", 32'(tag_out), 32'd1);
        out_ready = 1'b1;
        step();
        chk("bp_tag2", 32'(tag_out), 32'd2);
        step();
        chk("bp_tag3", 32'(tag_out), 32'd3);
        drive(1'b0, 3'd0, '0, '0, '0);
        step();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Reset between edges with both slots full
        out_ready = 1'b0;
        drive(1'b1, 3'd7, 8'h55, 8'h66, 4'd9);
        step();
        drive(1'b1, 3'd1, 8'h77, 8'h88, 4'd10);
        step();
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd1);
        chk("arst_a", 32'(a_out), 32'd0);
        chk("arst_tag", 32'(tag_out), 32'd0);
        chk("arst_err", 32'(err_sticky), 32'd0);
        drive(1'b0, 3'd0, '0, '0, '0);
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_empty", 32'(out_valid), 32'd0);
        end

        // Randomized phase; a refused beat is held stable until taken
        for (int i = 0; i < 3000; i++) begin
            if (!(in_valid && !last_acc)) begin
                drive(($urandom_range(0, 99) < 70), 3'($urandom_range(0, 7)),
                      8'($urandom), 8'($urandom), 4'($urandom));
            end
            out_ready = ($urandom_range(0, 99) < 60);
            err_clr   = ($urandom_range(0, 99) < 5);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
